// File: rtl/eth_rx_frame_trimmer_512.sv
// RX frame trimmer for the 512-bit CMAC path: strips IPv4 min-size padding, drops runts, truncates oversize frames.
// Statistics counters are built only when RX_TRIM_STATS_EN is defined; otherwise stat_* are tied to zero.
module eth_rx_frame_trimmer_512 #(
    parameter int MAX_FRAME_BYTES = 9216,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                 net_clk,
    input  logic                 sys_reset,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [511:0]         s_axis_tdata,
    input  logic [63:0]          s_axis_tkeep,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [511:0]         m_axis_tdata,
    output logic [63:0]          m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic [CNT_WIDTH-1:0] stat_frames,
    output logic [CNT_WIDTH-1:0] stat_trimmed,
    output logic [CNT_WIDTH-1:0] stat_runt,
    output logic [CNT_WIDTH-1:0] stat_truncated
);

    localparam logic [1:0]  S_HEAD    = 2'd0;
    localparam logic [1:0]  S_BODY    = 2'd1;
    localparam logic [1:0]  S_DROP    = 2'd2;
    localparam logic [31:0] MAX_BYTES = 32'(MAX_FRAME_BYTES);

    logic [1:0]   state_q, state_d;
    logic [15:0]  byte_cnt_q, byte_cnt_d;
    logic         m_tvalid_q, m_tvalid_d;
    logic [511:0] m_tdata_q, m_tdata_d;
    logic [63:0]  m_tkeep_q, m_tkeep_d;
    logic         m_tlast_q, m_tlast_d;

    logic         accept;
    logic         fwd;
    logic [6:0]   nb;
    logic [15:0]  ethertype;
    logic [3:0]   ip_ver;
    logic [15:0]  tot_len;
    logic [16:0]  trim_len;
    logic [63:0]  trim_keep;
    logic [16:0]  cnt_sum;
    logic         is_runt;
    logic         trim_ok;
    logic         over_limit;

    assign s_axis_tready = !m_tvalid_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        nb = '0;
        for (int i = 0; i < 64; i++) begin
            nb = nb + {6'd0, s_axis_tkeep[i]};
        end
    end

    // Header fields are only meaningful on the first beat of a frame.
    assign ethertype = {s_axis_tdata[8*12 +: 8], s_axis_tdata[8*13 +: 8]};
    assign ip_ver    = s_axis_tdata[8*14+4 +: 4];
    assign tot_len   = {s_axis_tdata[8*16 +: 8], s_axis_tdata[8*17 +: 8]};
    assign trim_len  = {1'b0, tot_len} + 17'd14;

    always_comb begin
        trim_keep = '0;
        for (int i = 0; i < 64; i++) begin
            trim_keep[i] = (17'(i) < trim_len);
        end
    end

    assign is_runt = (state_q == S_HEAD) && s_axis_tlast && (nb < 7'd14);
    assign trim_ok = (state_q == S_HEAD) && s_axis_tlast && (ethertype == 16'h0800) &&
                     (ip_ver == 4'h4) && (tot_len >= 16'd20) && (trim_len < {10'd0, nb});

    // A header beat starts a fresh count, so the stale byte_cnt_q is ignored there.
    assign cnt_sum    = ((state_q == S_HEAD) ? 17'd0 : {1'b0, byte_cnt_q}) + {10'd0, nb};
    assign over_limit = !s_axis_tlast && ({15'd0, cnt_sum} >= MAX_BYTES);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        fwd        = 1'b0;
        if (accept) begin
            case (state_q)
                S_HEAD, S_BODY: begin
                    if (!is_runt) begin
                        fwd        = 1'b1;
                        byte_cnt_d = cnt_sum[15:0];
                        if (over_limit) begin
                            state_d = S_DROP;
                        end else if (s_axis_tlast) begin
                            state_d = S_HEAD;
                        end else begin
                            state_d = S_BODY;
                        end
                    end
                end
                S_DROP: begin
                    if (s_axis_tlast) begin
                        state_d = S_HEAD;
                    end
                end
                default: state_d = S_HEAD;
            endcase
        end
    end

    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        if (fwd) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = s_axis_tdata;
            m_tkeep_d  = trim_ok ? trim_keep : s_axis_tkeep;
            m_tlast_d  = s_axis_tlast || over_limit;
        end else if (m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge net_clk) begin
        if (sys_reset) begin
            state_q    <= S_HEAD;
            byte_cnt_q <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tlast  = m_tlast_q;

`ifdef RX_TRIM_STATS_EN
    logic [CNT_WIDTH-1:0] frames_q, frames_d;
    logic [CNT_WIDTH-1:0] trimmed_q, trimmed_d;
    logic [CNT_WIDTH-1:0] runt_q, runt_d;
    logic [CNT_WIDTH-1:0] truncated_q, truncated_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
        return (en && !(&v)) ? v + CNT_WIDTH'(1) : v;
    endfunction

    // Events are counted when the beat is loaded into the output register.
    always_comb begin
        frames_d    = sat_inc(frames_q, fwd && m_tlast_d);
        trimmed_d   = sat_inc(trimmed_q, fwd && trim_ok);
        runt_d      = sat_inc(runt_q, accept && is_runt);
        truncated_d = sat_inc(truncated_q, fwd && over_limit);
    end

    always_ff @(posedge net_clk) begin
        if (sys_reset) begin
            frames_q    <= '0;
            trimmed_q   <= '0;
            runt_q      <= '0;
            truncated_q <= '0;
        end else begin
            frames_q    <= frames_d;
            trimmed_q   <= trimmed_d;
            runt_q      <= runt_d;
            truncated_q <= truncated_d;
        end
    end

    assign stat_frames    = frames_q;
    assign stat_trimmed   = trimmed_q;
    assign stat_runt      = runt_q;
    assign stat_truncated = truncated_q;
`else
    assign stat_frames    = '0;
    assign stat_trimmed   = '0;
    assign stat_runt      = '0;
    assign stat_truncated = '0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_trimmer_512.sv
// Directed testbench for eth_rx_frame_trimmer_512: trimming, runts, truncation, backpressure and mid-frame reset.
// Statistic expectations follow RX_TRIM_STATS_EN (zero when the counters are not built).
module tb_eth_rx_frame_trimmer_512;

`ifdef RX_TRIM_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic         net_clk = 1'b0;
    logic         sys_reset = 1'b1;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic [511:0] s_axis_tdata = '0;
    logic [63:0]  s_axis_tkeep = '0;
    logic         s_axis_tlast = 1'b0;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic [31:0]  stat_frames, stat_trimmed, stat_runt, stat_truncated;

    int checks = 0;
    int failures = 0;
    bit bp_en = 1'b0;

    logic [511:0] out_data[$];
    logic [63:0]  out_keep[$];
    logic         out_last[$];

    eth_rx_frame_trimmer_512 #(.MAX_FRAME_BYTES(9216), .CNT_WIDTH(32)) dut (
        .net_clk        (net_clk),
        .sys_reset      (sys_reset),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .stat_frames    (stat_frames),
        .stat_trimmed   (stat_trimmed),
        .stat_runt      (stat_runt),
        .stat_truncated (stat_truncated)
    );

    always #5 net_clk = ~net_clk;

    always @(posedge net_clk) begin
        #1;
        m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Signals are stable at the falling edge; a beat seen here transfers on the next rising edge.
    always @(negedge net_clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            out_data.push_back(m_axis_tdata);
            out_keep.push_back(m_axis_tkeep);
            out_last.push_back(m_axis_tlast);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge net_clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [511:0] d, input logic [63:0] k, input logic l);
        int  budget;
        logic took;
        budget = 200;
        took = 1'b0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!took && budget > 0) begin
            @(negedge net_clk);
            took = s_axis_tready;
            @(posedge net_clk);
            #1;
            budget--;
        end
        s_axis_tvalid = 1'b0;
        check_output("input_accepted", {511'd0, took}, 512'd1);
    endtask

    task automatic wait_out(input int n, input string tag);
        int budget;
        budget = 400;
        while (out_data.size() < n && budget > 0) begin
            cycle(1);
            budget--;
        end
        check_output(tag, 512'(out_data.size()), 512'(n));
    endtask

    function automatic logic [31:0] se(input int n);
        return STATS_ON ? 32'(n) : 32'd0;
    endfunction

    task automatic check_stats(input string tag, input int f, input int t, input int r, input int tr);
        check_output({tag, "_frames"}, 512'(stat_frames), 512'(se(f)));
        check_output({tag, "_trimmed"}, 512'(stat_trimmed), 512'(se(t)));
        check_output({tag, "_runt"}, 512'(stat_runt), 512'(se(r)));
        check_output({tag, "_truncated"}, 512'(stat_truncated), 512'(se(tr)));
    endtask

    function automatic logic [511:0] pat(input logic [7:0] s);
        logic [511:0] d;
        for (int i = 0; i < 64; i++) d[8*i +: 8] = s + 8'(i);
        return d;
    endfunction

    function automatic logic [511:0] mk_frame(input logic [7:0] s, input logic [15:0] et,
                                              input logic [7:0] b14, input logic [15:0] tl);
        logic [511:0] d;
        d = pat(s);
        d[8*12 +: 8] = et[15:8];
        d[8*13 +: 8] = et[7:0];
        d[8*14 +: 8] = b14;
        d[8*16 +: 8] = tl[15:8];
        d[8*17 +: 8] = tl[7:0];
        return d;
    endfunction

    localparam logic [63:0] KEEP_ALL = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] KEEP_60  = 64'h0FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] KEEP_59  = 64'h07FF_FFFF_FFFF_FFFF;
    localparam logic [63:0] KEEP_42  = 64'h0000_03FF_FFFF_FFFF;

    initial begin
        logic [511:0] d;
        logic [511:0] exp_d[5];
        logic [63:0]  exp_k[5];
        logic         exp_l[5];
        int bad;

        // Reset state
        sys_reset = 1'b1;
        cycle(3);
        check_output("rst_tvalid", 512'(m_axis_tvalid), 512'd0);
        check_output("rst_tlast", 512'(m_axis_tlast), 512'd0);
        check_output("rst_tkeep", 512'(m_axis_tkeep), 512'd0);
        check_output("rst_tdata", m_axis_tdata, 512'd0);
        check_stats("rst", 0, 0, 0, 0);
        sys_reset = 1'b0;
        cycle(1);
        check_output("rst_tready", 512'(s_axis_tready), 512'd1);

        // IPv4 single beat with total length 28 -> trimmed to 42 bytes
        d = mk_frame(8'h10, 16'h0800, 8'h45, 16'h001C);
        apply_stimulus(d, KEEP_ALL, 1'b1);
        wait_out(1, "trim_count");
        check_output("trim_data", out_data[0], d);
        check_output("trim_keep", 512'(out_keep[0]), 512'(KEEP_42));
        check_output("trim_last", 512'(out_last[0]), 512'd1);
        check_stats("trim", 1, 1, 0, 0);

        // 60-byte ARP frame passes untouched
        d = mk_frame(8'h20, 16'h0806, 8'h00, 16'h0000);
        apply_stimulus(d, KEEP_60, 1'b1);
        wait_out(2, "arp_count");
        check_output("arp_data", out_data[1], d);
        check_output("arp_keep", 512'(out_keep[1]), 512'(KEEP_60));
        check_output("arp_last", 512'(out_last[1]), 512'd1);
        check_stats("arp", 2, 1, 0, 0);

        // 10-byte runt is dropped, next frame passes
        apply_stimulus(pat(8'h30), 64'h3FF, 1'b1);
        cycle(3);
        check_output("runt_no_output", 512'(out_data.size()), 512'd2);
        check_stats("runt", 2, 1, 1, 0);
        apply_stimulus(pat(8'h31), KEEP_ALL, 1'b1);
        wait_out(3, "after_runt_count");
        check_output("after_runt_data", out_data[2], pat(8'h31));
        check_output("after_runt_keep", 512'(out_keep[2]), 512'(KEEP_ALL));

        // Trim boundaries: 14+tl == nb (no trim), tl < 20 (no trim), 14+tl == nb-1 (trim)
        d = mk_frame(8'h40, 16'h0800, 8'h45, 16'd46);
        apply_stimulus(d, KEEP_60, 1'b1);
        wait_out(4, "eq_len_count");
        check_output("eq_len_keep", 512'(out_keep[3]), 512'(KEEP_60));
        d = mk_frame(8'h41, 16'h0800, 8'h45, 16'd19);
        apply_stimulus(d, KEEP_ALL, 1'b1);
        wait_out(5, "short_tl_count");
        check_output("short_tl_keep", 512'(out_keep[4]), 512'(KEEP_ALL));
        d = mk_frame(8'h42, 16'h0800, 8'h45, 16'd45);
        apply_stimulus(d, KEEP_60, 1'b1);
        wait_out(6, "one_less_count");
        check_output("one_less_keep", 512'(out_keep[5]), 512'(KEEP_59));
        check_stats("bounds", 6, 2, 1, 0);

        // 145 full beats: 144 forwarded with forced tlast, beat 145 absorbed
        for (int i = 0; i < 145; i++) apply_stimulus(pat(8'(i)), KEEP_ALL, (i == 144));
        wait_out(150, "trunc_count");
        cycle(3);
        check_output("trunc_no_extra", 512'(out_data.size()), 512'd150);
        bad = 0;
        for (int i = 0; i < 144; i++) begin
            if (out_data[6+i] !== pat(8'(i)) || out_last[6+i] !== (i == 143)) bad++;
        end
        check_output("trunc_beats_bad", 512'(bad), 512'd0);
        check_output("trunc_forced_last", 512'(out_last[149]), 512'd1);
        check_stats("trunc", 7, 2, 1, 1);

        apply_stimulus(pat(8'hA0), KEEP_ALL, 1'b0);
        apply_stimulus(pat(8'hA1), 64'hFF, 1'b1);
        wait_out(152, "post_trunc_count");
        check_output("post_trunc_d0", out_data[150], pat(8'hA0));
        check_output("post_trunc_l0", 512'(out_last[150]), 512'd0);
        check_output("post_trunc_k1", 512'(out_keep[151]), 512'h0FF);
        check_output("post_trunc_l1", 512'(out_last[151]), 512'd1);

        // Exactly MAX_FRAME_BYTES ending in tlast is not truncated
        for (int i = 0; i < 144; i++) apply_stimulus(pat(8'(i + 3)), KEEP_ALL, (i == 143));
        wait_out(296, "exact_count");
        bad = 0;
        for (int i = 0; i < 144; i++) begin
            if (out_data[152+i] !== pat(8'(i + 3)) || out_last[152+i] !== (i == 143)) bad++;
        end
        check_output("exact_beats_bad", 512'(bad), 512'd0);
        check_stats("exact", 9, 2, 1, 1);

        // Three mixed frames under random backpressure
        exp_d[0] = mk_frame(8'h50, 16'h0800, 8'h45, 16'h001C); exp_k[0] = KEEP_42;  exp_l[0] = 1'b1;
        exp_d[1] = pat(8'h60);                                  exp_k[1] = KEEP_ALL; exp_l[1] = 1'b0;
        exp_d[2] = pat(8'h61);                                  exp_k[2] = KEEP_ALL; exp_l[2] = 1'b0;
        exp_d[3] = pat(8'h62);                                  exp_k[3] = 64'hFFFF; exp_l[3] = 1'b1;
        exp_d[4] = mk_frame(8'h70, 16'h0806, 8'h00, 16'h0000); exp_k[4] = KEEP_60;  exp_l[4] = 1'b1;
        bp_en = 1'b1;
        apply_stimulus(exp_d[0], KEEP_ALL, 1'b1);
        apply_stimulus(exp_d[1], KEEP_ALL, 1'b0);
        apply_stimulus(exp_d[2], KEEP_ALL, 1'b0);
        apply_stimulus(exp_d[3], 64'hFFFF, 1'b1);
        apply_stimulus(exp_d[4], KEEP_60, 1'b1);
        wait_out(301, "bp_count");
        bp_en = 1'b0;
        cycle(4);
        check_output("bp_no_extra", 512'(out_data.size()), 512'd301);
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("bp_data%0d", i), out_data[296+i], exp_d[i]);
            check_output($sformatf("bp_keep%0d", i), 512'(out_keep[296+i]), 512'(exp_k[i]));
            check_output($sformatf("bp_last%0d", i), 512'(out_last[296+i]), 512'(exp_l[i]));
        end
        check_stats("bp", 12, 3, 1, 1);

        // Reset on beat 3 of a 5-beat frame; the following beat is parsed as a header
        apply_stimulus(pat(8'hB0), KEEP_ALL, 1'b0);
        apply_stimulus(pat(8'hB1), KEEP_ALL, 1'b0);
        s_axis_tdata  = pat(8'hB2);
        s_axis_tkeep  = KEEP_ALL;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        sys_reset     = 1'b1;
        cycle(1);
        sys_reset     = 1'b0;
        s_axis_tvalid = 1'b0;
        check_output("mid_rst_tvalid", 512'(m_axis_tvalid), 512'd0);
        check_stats("mid_rst", 0, 0, 0, 0);
        check_output("mid_rst_out_count", 512'(out_data.size()), 512'd303);
        apply_stimulus(pat(8'hC0), 64'h3FF, 1'b1);
        cycle(3);
        check_output("mid_rst_runt_dropped", 512'(out_data.size()), 512'd303);
        check_stats("mid_rst_runt", 0, 0, 1, 0);
        apply_stimulus(pat(8'hC1), KEEP_ALL, 1'b1);
        wait_out(304, "mid_rst_next_count");
        check_output("mid_rst_next_data", out_data[303], pat(8'hC1));
        check_output("mid_rst_next_last", 512'(out_last[303]), 512'd1);
        check_stats("mid_rst_next", 1, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
